// File: rtl/maze_store.sv
// Wall/path bitmap store for the maze solver: byte-serial wall load, per-cell path marking, row readback.
// Optional MAZE_STORE_PATH_COUNT_EN adds o_path_count, a saturating count of distinct marked cells.
module maze_store #(
    parameter int MAZE_WIDTH = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [MAZE_WIDTH-1:0]        i_row,
    input  logic [MAZE_WIDTH-1:0]        i_col,
    input  logic                         i_maze_oe,
    input  logic                         i_maze_we,
    input  logic                         i_done,
    output logic                         o_maze_in,
    input  logic                         i_load_start,
    input  logic                         i_load_valid,
    input  logic [7:0]                   i_load_data,
    output logic                         o_load_ready,
    output logic                         o_maze_ready,
    input  logic                         i_rd_en,
    input  logic [MAZE_WIDTH-1:0]        i_rd_row,
    output logic [(1<<MAZE_WIDTH)-1:0]   o_rd_path
`ifdef MAZE_STORE_PATH_COUNT_EN
    ,
    output logic [2*MAZE_WIDTH:0]        o_path_count
`endif
);
    localparam int W   = MAZE_WIDTH;
    localparam int DIM = 1 << W;
    localparam int BCW = 2 * W - 3;

    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_READY, S_DONE} state_t;

    state_t           r_state;
    logic [W-1:0]     r_row;
    logic [BCW-1:0]   r_byte_cnt;
    logic             r_maze_in;
    logic             r_load_ready;
    logic             r_maze_ready;
    logic [DIM-1:0]   r_rd_path;
    logic [DIM-1:0]   r_wall [DIM];
    logic [DIM-1:0]   r_path [DIM];

    // Byte index * 8 is the flat bit index: high half is the row, low half the column lsb.
    logic [2*W-1:0]   w_bit_idx;
    logic [W-1:0]     w_ld_row;
    logic [W-1:0]     w_ld_lsb;
    logic             w_accept;
    logic             w_last;
    logic             w_mark;
    logic             w_serviced;

    assign w_bit_idx  = {r_byte_cnt, 3'b000};
    assign w_ld_row   = w_bit_idx[2*W-1:W];
    assign w_ld_lsb   = w_bit_idx[W-1:0];
    assign w_accept   = (r_state == S_LOAD) && i_load_valid && !i_load_start;
    assign w_last     = &r_byte_cnt;
    assign w_mark     = (r_state == S_READY) && i_maze_we && !i_load_start;
    assign w_serviced = (r_state == S_READY) || (r_state == S_DONE);

    assign o_maze_in    = r_maze_in;
    assign o_load_ready = r_load_ready;
    assign o_maze_ready = r_maze_ready;
    assign o_rd_path    = r_rd_path;

    // Bitmaps carry no reset; the CLEAR sweep after every reset/load_start zeroes them.
    always_ff @(posedge i_clk) begin
        if (r_state == S_CLEAR) begin
            r_wall[r_row] <= '0;
            r_path[r_row] <= '0;
        end
        if (w_accept) begin
            r_wall[w_ld_row][w_ld_lsb +: 8] <= i_load_data;
        end
        if (w_mark) begin
            r_path[i_row][i_col] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_CLEAR;
            r_row        <= '0;
            r_byte_cnt   <= '0;
            r_maze_in    <= 1'b1;
            r_load_ready <= 1'b0;
            r_maze_ready <= 1'b0;
            r_rd_path    <= '0;
        end else begin
            if (i_maze_oe) begin
                r_maze_in <= w_serviced ? r_wall[i_row][i_col] : 1'b1;
            end
            if (i_rd_en && w_serviced) begin
                r_rd_path <= r_path[i_rd_row];
            end
            if (i_load_start) begin
                r_state      <= S_CLEAR;
                r_row        <= '0;
                r_byte_cnt   <= '0;
                r_load_ready <= 1'b0;
                r_maze_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        r_row <= r_row + 1'b1;
                        if (&r_row) begin
                            r_state      <= S_LOAD;
                            r_load_ready <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (w_accept) begin
                            r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
                            if (w_last) begin
                                r_state      <= S_READY;
                                r_load_ready <= 1'b0;
                                r_maze_ready <= 1'b1;
                            end
                        end
                    end
                    S_READY: begin
                        if (i_done) begin
                            r_state <= S_DONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef MAZE_STORE_PATH_COUNT_EN
    logic [2*W:0] r_path_count;

    assign o_path_count = r_path_count;

    // Only a 0->1 transition of a path bit counts, so re-marking a cell is free.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_path_count <= '0;
        end else if (i_load_start) begin
            r_path_count <= '0;
        end else if (w_mark && !r_path[i_row][i_col]
                     && (r_path_count != (2*W+1)'(DIM * DIM))) begin
            r_path_count <= r_path_count + 1'b1;
        end
    end
`endif

endmodule
